// File: rtl/controller_pkg.sv
// Shared types and constants for the serial gamepad host interface.
package controller_pkg;

    localparam int NUM_BUTTONS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        SHIFT,
        DONE
    } state_t;

    // Bit positions in the published button byte; A is the first bit shifted out.
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/controller_if.sv
// Pad-side and CPU-side signals of the gamepad host; master is the host block.
interface controller_if #(
    parameter int NUM_BUTTONS = controller_pkg::NUM_BUTTONS_DEFAULT
) ();

    logic                   poll;
    logic                   controller_clk_out_enable;
    logic                   controller_latch;
    logic                   controller_1_data_in_B;
    logic                   controller_2_data_in_B;
    logic [NUM_BUTTONS-1:0] controller_1_buttons_out;
    logic [NUM_BUTTONS-1:0] controller_2_buttons_out;
    logic                   busy;
    logic                   done;

    modport master (
        input  poll,
        input  controller_1_data_in_B,
        input  controller_2_data_in_B,
        output controller_clk_out_enable,
        output controller_latch,
        output controller_1_buttons_out,
        output controller_2_buttons_out,
        output busy,
        output done
    );

    modport slave (
        output poll,
        output controller_1_data_in_B,
        output controller_2_data_in_B,
        input  controller_clk_out_enable,
        input  controller_latch,
        input  controller_1_buttons_out,
        input  controller_2_buttons_out,
        input  busy,
        input  done
    );

endinterface

// File: rtl/controller_deserializer.sv
// One pad's shadow shift register and committed button byte, strobed by the shared FSM.
module controller_deserializer #(
    parameter int NUM_BUTTONS = controller_pkg::NUM_BUTTONS_DEFAULT
) (
    input  logic                   clk_1,
    input  logic                   rst,
    input  logic                   capture,
    input  logic                   commit,
    input  logic                   data_in_B,
    output logic [NUM_BUTTONS-1:0] buttons_out
);

    // The final bit goes straight into the committed byte, so the shadow
    // only needs to hold the first NUM_BUTTONS-1 bits.
    logic [NUM_BUTTONS-2:0] shadow;
    logic [NUM_BUTTONS-1:0] assembled;

    assign assembled = {shadow, ~data_in_B};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    // NOTE: shadow is a handful of flops, not a RAM, so it is cleared on reset
    // to make an aborted poll leave nothing behind.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            shadow      <= '0;
            buttons_out <= '0;
        end else begin
            if (capture) begin
                shadow <= assembled[NUM_BUTTONS-2:0];
            end
            if (commit) begin
                buttons_out <= assembled;
            end
        end
    end

endmodule

// File: rtl/controller.sv
// Serial gamepad host: latch, shift and publish two NES-style pads in parallel.
// Optional build macro CONTROLLER_AUTOPOLL_EN polls every POLL_PERIOD cycles and ignores the poll port.
module controller
    import controller_pkg::*;
#(
    parameter int NUM_BUTTONS = NUM_BUTTONS_DEFAULT
`ifdef CONTROLLER_AUTOPOLL_EN
    ,
    parameter int POLL_PERIOD = 16384
`endif
) (
    input  logic            clk_1,
    input  logic            rst,
    controller_if.master    bus
);

    localparam int CNT_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BUTTONS - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic             poll_req;
    logic             capture;
    logic             commit;

`ifdef CONTROLLER_AUTOPOLL_EN
    localparam int PCNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [PCNT_W-1:0] POLL_LAST = PCNT_W'(POLL_PERIOD - 1);

    logic [PCNT_W-1:0] poll_cnt;
    logic              unused_poll;

    assign unused_poll = bus.poll;
    assign poll_req    = (poll_cnt == POLL_LAST);

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            poll_cnt <= '0;
        end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end
`else
    assign poll_req = bus.poll;
`endif

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
        end
    end

    // Outputs decode straight from the state register, so a reset clears them
    // in the same instant it clears the state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned and infers a latch.
        state_next                    = state;
        bit_cnt_next                  = bit_cnt;
        bus.controller_latch          = 1'b0;
        bus.controller_clk_out_enable = 1'b0;
        bus.busy                      = 1'b0;
        bus.done                      = 1'b0;
        capture                       = 1'b0;
        commit                        = 1'b0;

        unique case (state)
            IDLE: begin
                if (poll_req) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                bus.controller_latch = 1'b1;
                bus.busy             = 1'b1;
                bit_cnt_next         = '0;
                state_next           = SHIFT;
            end
            SHIFT: begin
                bus.controller_clk_out_enable = 1'b1;
                bus.busy                      = 1'b1;
                capture                       = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    commit       = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = DONE;
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    controller_deserializer #(.NUM_BUTTONS(NUM_BUTTONS)) u_port_1 (
        .clk_1       (clk_1),
        .rst         (rst),
        .capture     (capture),
        .commit      (commit),
        .data_in_B   (bus.controller_1_data_in_B),
        .buttons_out (bus.controller_1_buttons_out)
    );

    controller_deserializer #(.NUM_BUTTONS(NUM_BUTTONS)) u_port_2 (
        .clk_1       (clk_1),
        .rst         (rst),
        .capture     (capture),
        .commit      (commit),
        .data_in_B   (bus.controller_2_data_in_B),
        .buttons_out (bus.controller_2_buttons_out)
    );

endmodule

// File: tb/tb_controller.sv
// Bench for controller: behavioural pad models plus directed and random polls.
module tb_controller;
    import controller_pkg::*;

    logic clk_1 = 1'b0;
    logic rst   = 1'b1;

    controller_if bus ();

    always #5 clk_1 = ~clk_1;

`ifdef CONTROLLER_AUTOPOLL_EN
    controller #(.NUM_BUTTONS(8), .POLL_PERIOD(32)) dut (
        .clk_1 (clk_1),
        .rst   (rst),
        .bus   (bus)
    );
`else
    controller #(.NUM_BUTTONS(8)) dut (
        .clk_1 (clk_1),
        .rst   (rst),
        .bus   (bus)
    );
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Pad models: what each player is holding, and whether the pad is plugged in.
    logic [7:0] pad1 = 8'h00, pad2 = 8'h00;
    logic       conn1 = 1'b1, conn2 = 1'b1;
    logic       d1 = 1'b1, d2 = 1'b1;
    int         pulse_cnt = 0;
    logic [7:0] exp1 = 8'h00, exp2 = 8'h00;

    wire gclk = ~clk_1 & bus.controller_clk_out_enable;

    assign bus.controller_1_data_in_B = d1;
    assign bus.controller_2_data_in_B = d2;

    // Latch presents A; each gated pulse presents the bit the host samples at
    // the end of that cycle, walking A..Right. Unplugged lines float high.
    always @(posedge bus.controller_latch or posedge gclk) begin
        if (bus.controller_latch) begin
            pulse_cnt = 0;
            d1 = conn1 ? ~pad1[7] : 1'b1;
            d2 = conn2 ? ~pad2[7] : 1'b1;
        end else begin
            if (pulse_cnt < 8) begin
                d1 = conn1 ? ~pad1[7 - pulse_cnt] : 1'b1;
                d2 = conn2 ? ~pad2[7 - pulse_cnt] : 1'b1;
            end
            pulse_cnt = pulse_cnt + 1;
        end
    end

    int latch_cycles = 0, done_cycles = 0, overlap_cycles = 0;
    always @(negedge clk_1) begin
        if (bus.controller_latch === 1'b1) latch_cycles = latch_cycles + 1;
        if (bus.done === 1'b1) done_cycles = done_cycles + 1;
        if (bus.controller_latch === 1'b1 && bus.controller_clk_out_enable === 1'b1)
            overlap_cycles = overlap_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] btn_mask(input int a, input int b);
        logic [7:0] m;
        m = '0;
        m[a] = 1'b1;
        m[b] = 1'b1;
        return m;
    endfunction

    // Called at #1 after a rising edge; that cycle is cycle 0 of the poll.
    task automatic run_poll(input string name, input logic [7:0] p1, input logic [7:0] p2,
                            input logic c1, input logic c2, input logic extra);
        int l0, dn0;
        logic [7:0] new1, new2;
        pad1 = p1; pad2 = p2; conn1 = c1; conn2 = c2;
        new1 = c1 ? p1 : 8'h00;
        new2 = c2 ? p2 : 8'h00;
        l0 = latch_cycles;
        dn0 = done_cycles;
        bus.poll = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk_1);
            #1;
            bus.poll = extra && (c == 3 || c == 10);
            if (c == 1) begin
                check({name, " latch c1"}, bus.controller_latch, 1);
                check({name, " enable c1"}, bus.controller_clk_out_enable, 0);
                check({name, " busy c1"}, bus.busy, 1);
            end else if (c <= 9) begin
                check($sformatf("%s latch c%0d", name, c), bus.controller_latch, 0);
                check($sformatf("%s enable c%0d", name, c), bus.controller_clk_out_enable, 1);
                check($sformatf("%s hold1 c%0d", name, c), bus.controller_1_buttons_out, exp1);
                check($sformatf("%s hold2 c%0d", name, c), bus.controller_2_buttons_out, exp2);
                check($sformatf("%s done c%0d", name, c), bus.done, 0);
            end else if (c == 10) begin
                check({name, " done c10"}, bus.done, 1);
                check({name, " busy c10"}, bus.busy, 0);
                check({name, " enable c10"}, bus.controller_clk_out_enable, 0);
                check({name, " buttons1"}, bus.controller_1_buttons_out, new1);
                check({name, " buttons2"}, bus.controller_2_buttons_out, new2);
            end else begin
                check({name, " done c11"}, bus.done, 0);
                check({name, " latch c11"}, bus.controller_latch, 0);
                check({name, " busy c11"}, bus.busy, 0);
            end
        end
        bus.poll = 1'b0;
        @(negedge clk_1);
        check({name, " latch pulses"}, latch_cycles - l0, 1);
        check({name, " done pulses"}, done_cycles - dn0, 1);
        check({name, " gated pulses"}, pulse_cnt, 8);
        exp1 = new1;
        exp2 = new2;
        @(posedge clk_1);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.poll = 1'b0;
        #2;
        check("reset latch", bus.controller_latch, 0);
        check("reset enable", bus.controller_clk_out_enable, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset buttons1", bus.controller_1_buttons_out, 8'h00);
        check("reset buttons2", bus.controller_2_buttons_out, 8'h00);
        @(negedge clk_1);
        rst = 1'b0;

`ifdef CONTROLLER_AUTOPOLL_EN
        begin
            int seen[$];
            for (int c = 1; c <= 100; c++) begin
                @(posedge clk_1);
                #1;
                if (bus.controller_latch === 1'b1) seen.push_back(c);
                bus.poll = 1'($urandom);
            end
            bus.poll = 1'b0;
            check("autopoll count", seen.size(), 3);
            for (int i = 0; i < 3; i++) begin
                if (i < seen.size())
                    check($sformatf("autopoll latch %0d", i), seen[i], 32 * (i + 1));
            end
        end
`else
        run_poll("a_start_right", btn_mask(BTN_A, BTN_START), btn_mask(BTN_RIGHT, BTN_RIGHT),
                 1'b1, 1'b1, 1'b0);
        check("a_start value", exp1, 8'h90);
        run_poll("idle_lines", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        run_poll("all_pressed", 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        run_poll("extra_polls", btn_mask(BTN_B, BTN_UP), btn_mask(BTN_SELECT, BTN_DOWN),
                 1'b1, 1'b1, 1'b1);
        run_poll("all_pressed2", 8'hFF, btn_mask(BTN_LEFT, BTN_A) | 8'hFF, 1'b1, 1'b1, 1'b0);

        // Abort a poll with reset in cycle 5.
        pad1 = 8'h3C; pad2 = 8'hC3;
        bus.poll = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk_1);
            #1;
            bus.poll = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("abort buttons1", bus.controller_1_buttons_out, 8'h00);
        check("abort buttons2", bus.controller_2_buttons_out, 8'h00);
        check("abort latch", bus.controller_latch, 0);
        check("abort enable", bus.controller_clk_out_enable, 0);
        check("abort busy", bus.busy, 0);
        exp1 = 8'h00;
        exp2 = 8'h00;
        @(negedge clk_1);
        rst = 1'b0;
        @(posedge clk_1);
        #1;
        run_poll("after_abort", 8'h5A, 8'hA5, 1'b1, 1'b1, 1'b0);

        // No poll, no latch.
        begin
            int l0;
            l0 = latch_cycles;
            repeat (40) @(posedge clk_1);
            #1;
            check("no poll no latch", latch_cycles - l0, 0);
        end

        for (int i = 0; i < 8; i++) begin
            run_poll($sformatf("rand%0d", i), 8'($urandom), 8'($urandom),
                     ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                     1'($urandom));
        end
`endif

        check("latch enable overlap", overlap_cycles, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/controller.md
Name: controller

Overview:
- Host-side serial gamepad interface for the console FPGA; two instances of its logic are not needed, since one block serves both ports.
- On a poll request it pulses a shared latch, then shifts 8 bits from two NES-style controllers in parallel.
- Serial data is active-low; the block inverts it and publishes two registered 8-bit button bytes to the CPU bus logic.
- Lives in the controller_interface area of top_m, beside the memory-map decode that selects controller 1/2 reads.

Parameters:
- NUM_BUTTONS, 8, bits shifted per controller per poll.
- POLL_PERIOD, 16384, clk_1 cycles between automatic polls; used only with the optional feature.

Ports:
- clk_1  in  1  system/CPU clock; all logic is on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- poll  in  1  poll request, sampled high for one cycle; top level drives it from the vblank start.
- controller_clk_out_enable  out  1  gate for the shared controller clock; top level forms controller_clk_in = ~clk_1 & enable.
- controller_latch  out  1  parallel-load strobe to both controllers.
- controller_1_data_in_B  in  1  serial data from controller 1, active-low (0 = pressed).
- controller_2_data_in_B  in  1  serial data from controller 2, active-low.
- controller_1_buttons_out  out  8  controller 1 state, 1 = pressed.
- controller_2_buttons_out  out  8  controller 2 state, 1 = pressed.
- busy  out  1  high while a poll is in progress.
- done  out  1  one-cycle pulse in the cycle the button outputs update.

Behaviour:
- Reset values: latch=0, enable=0, busy=0, done=0, both buttons_out=8'h00, state=IDLE, bit counter=0.
- FSM states: IDLE, LATCH, SHIFT, DONE.
- IDLE: poll=1 moves to LATCH next cycle.
- LATCH: exactly one cycle; controller_latch=1, enable=0, busy=1.
- SHIFT: NUM_BUTTONS cycles, counter k=0..7, enable=1.
  - At the rising clk_1 edge that ends cycle k, capture ~data_in_B of each controller into shadow bit (7-k).
  - The gated clock's rising edge at mid-cycle (falling clk_1) advances each controller to the next bit.
  - First bit after the latch is A, which lands in bit 7.
- Bit map: 7=A, 6=B, 5=Select, 4=Start, 3=Up, 2=Down, 1=Left, 0=Right.
- DONE: one cycle.
  - Copy both shadow registers to buttons_out atomically; done=1, busy=0 from the next cycle.
  - Return to IDLE.
- Latency: poll at cycle 0 gives latch high in cycle 1, shift in cycles 2..9, done and outputs valid in cycle 10.
- buttons_out hold their old value for the whole poll; there is no partial update.
- poll while busy is ignored; no queueing.
- poll in the same cycle as DONE is also ignored.
- Reset mid-poll aborts immediately: all outputs go to reset values and the shadow registers clear.
- Enable is never high during LATCH, so the controllers are not clocked while loading.
- A disconnected controller (line pulled high) reads 8'h00.

Optional Feature:
- Macro: CONTROLLER_AUTOPOLL_EN.
- Defined:
  - A free-running counter triggers a poll every POLL_PERIOD cycles.
  - The poll port is ignored.
  - The counter resets to 0 on rst and the first poll fires at count POLL_PERIOD-1.
- Undefined: polls start only from the poll port, and no counter exists.

Decomposition:
- controller_pkg holds:
  - the state enum (IDLE, LATCH, SHIFT, DONE);
  - the NUM_BUTTONS default;
  - the button bit-index constants (BTN_A=7 … BTN_RIGHT=0).
- One natural sub-module, controller_deserializer, instantiated twice. It contains the shadow shift register and output register for one port, driven by the shared FSM's capture/commit strobes.

Test Plan:
- Reset, then poll with controller 1 holding A+Start and controller 2 holding Right → latch high in cycle 1 only, enable high cycles 2..9, done in cycle 10, outputs 8'h90 and 8'h01.
- Both controllers holding nothing (lines idle high) → outputs 8'h00; then all pressed → 8'hFF, with previous value held until done.
- poll pulsed again at cycles 3 and 10 of an active poll → ignored; exactly one latch pulse and one done pulse.
- Assert rst in cycle 5 of a poll while outputs were 8'hFF → immediate 8'h00, latch/enable/busy 0, and the next poll completes normally.
- Count gated-clock pulses per poll → exactly 8; latch and enable never overlap.
- With CONTROLLER_AUTOPOLL_EN and POLL_PERIOD=32 → latch pulses every 32 cycles regardless of poll; without it, no latch without poll.
